// File: rtl/flow_vga_pkg.sv
// Shared definitions for the VGA plot path: screen geometry, coordinate and
// colour widths, the packed pixel record, and the fill-engine / arbiter enums.
package flow_vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COLOR_W = 15;

    // Fill scan coordinates carry one extra bit so x0+w-1 / y0+h-1 never wrap.
    localparam int XE_W = X_W + 1;
    localparam int YE_W = Y_W + 1;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

    typedef enum logic {
        SRC_FIFO = 1'b0,
        SRC_FILL = 1'b1
    } src_t;

    function automatic logic on_screen(input logic [XE_W-1:0] x, input logic [YE_W-1:0] y);
        return (x < XE_W'(SCREEN_W)) && (y < YE_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO for single-pixel plot requests.
// Ports: clock, resetn (async, active-low), push/din write side (ignored when
// full), pop (ignored when empty), dout = current head (valid when !empty),
// full / empty flags. DEPTH must be a power of two, >= 2.
module plot_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry a wrap bit to tell full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vga_plot_scheduler.sv
// Merges single-pixel requests (via plot_fifo) and a rectangle-fill engine onto
// one registered VGA adapter plot port, one pixel per cycle at most.
// Ports: clock, resetn (async, active-low); pix_valid/pix_ready/pix_x/pix_y/
// pix_color pixel request stream; fill_start + fill_x0/y0/w/h/color rectangle
// command, fill_busy while scanning; vga_x/vga_y/vga_color/vga_plot registered
// plot port; idle when nothing is queued, scanning or being plotted.
//
// Fill FSM
//   state     | meaning
//   FILL_IDLE | waiting for fill_start with non-zero w and h
//   FILL_RUN  | scanning rectangle row-major, clipped rows skipped in one cycle
module vga_plot_scheduler
    import flow_vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [X_W-1:0]     pix_x,
    input  logic [Y_W-1:0]     pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               fill_start,
    input  logic [X_W-1:0]     fill_x0,
    input  logic [Y_W-1:0]     fill_y0,
    input  logic [X_W-1:0]     fill_w,
    input  logic [Y_W-1:0]     fill_h,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               fill_busy,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_plot,
    output logic               idle
);

    pixel_t fifo_head;
    pixel_t pix_in;
    pixel_t plot_data;
    logic   fifo_full, fifo_empty, fifo_pop;

    fill_state_t        state, state_nxt;
    src_t               rr, rr_nxt;
    logic [XE_W-1:0]    cx, cx_nxt, x0, x0_nxt, xend, xend_nxt;
    logic [YE_W-1:0]    cy, cy_nxt, yend, yend_nxt;
    logic [COLOR_W-1:0] fcolor, fcolor_nxt;

    logic fill_vis, fifo_vis, grant_fifo, grant_fill, plot_nxt;

    assign pix_in = '{x: pix_x, y: pix_y, color: pix_color};

    plot_fifo #(
        .WIDTH($bits(pixel_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .resetn(resetn),
        .push  (pix_valid),
        .din   (pix_in),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pix_ready = !fifo_full;
    assign fill_busy = (state == FILL_RUN);
    assign fill_vis  = (state == FILL_RUN) && on_screen(cx, cy);
    assign fifo_vis  = on_screen({1'b0, fifo_head.x}, {1'b0, fifo_head.y});
    assign fifo_pop  = grant_fifo;
    assign idle      = fifo_empty && (state == FILL_IDLE) && !vga_plot;

    // Off-screen FIFO heads still take a grant so they drain; they just never plot.
    assign plot_nxt  = grant_fill || (grant_fifo && fifo_vis);
    assign plot_data = grant_fill ? pixel_t'({cx[X_W-1:0], cy[Y_W-1:0], fcolor}) : fifo_head;

    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr;
        cx_nxt     = cx;
        cy_nxt     = cy;
        x0_nxt     = x0;
        xend_nxt   = xend;
        yend_nxt   = yend;
        fcolor_nxt = fcolor;
        grant_fifo = 1'b0;
        grant_fill = 1'b0;

        // The round-robin pointer only moves when both sources contend.
        if (!fifo_empty && fill_vis) begin
            grant_fifo = (rr == SRC_FIFO);
            grant_fill = (rr == SRC_FILL);
            rr_nxt     = (rr == SRC_FIFO) ? SRC_FILL : SRC_FIFO;
        end else begin
            grant_fifo = !fifo_empty;
            grant_fill = fill_vis;
        end

        case (state)
            FILL_IDLE: begin
                if (fill_start && (fill_w != '0) && (fill_h != '0)) begin
                    state_nxt  = FILL_RUN;
                    x0_nxt     = {1'b0, fill_x0};
                    cx_nxt     = {1'b0, fill_x0};
                    cy_nxt     = {1'b0, fill_y0};
                    xend_nxt   = {1'b0, fill_x0} + {1'b0, fill_w} - 1'b1;
                    yend_nxt   = {1'b0, fill_y0} + {1'b0, fill_h} - 1'b1;
                    fcolor_nxt = fill_color;
                end
            end
            FILL_RUN: begin
                if (cy >= YE_W'(SCREEN_H)) begin
                    // Every remaining row is below the screen.
                    state_nxt = FILL_IDLE;
                end else if (cx >= XE_W'(SCREEN_W)) begin
                    // Rest of this row is off the right edge.
                    if (cy == yend) begin
                        state_nxt = FILL_IDLE;
                    end else begin
                        cx_nxt = x0;
                        cy_nxt = cy + 1'b1;
                    end
                end else if (grant_fill) begin
                    if (cx == xend) begin
                        if (cy == yend) begin
                            state_nxt = FILL_IDLE;
                        end else begin
                            cx_nxt = x0;
                            cy_nxt = cy + 1'b1;
                        end
                    end else begin
                        cx_nxt = cx + 1'b1;
                    end
                end
            end
            default: state_nxt = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= FILL_IDLE;
            rr     <= SRC_FIFO;
            cx     <= '0;
            cy     <= '0;
            x0     <= '0;
            xend   <= '0;
            yend   <= '0;
            fcolor <= '0;
        end else begin
            state  <= state_nxt;
            rr     <= rr_nxt;
            cx     <= cx_nxt;
            cy     <= cy_nxt;
            x0     <= x0_nxt;
            xend   <= xend_nxt;
            yend   <= yend_nxt;
            fcolor <= fcolor_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_plot  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
        end else begin
            vga_plot <= plot_nxt;
            if (plot_nxt) begin
                vga_x     <= plot_data.x;
                vga_y     <= plot_data.y;
                vga_color <= plot_data.color;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
module tb_vga_plot_scheduler;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [14:0] pix_color;
    logic        fill_start;
    logic [7:0]  fill_x0;
    logic [6:0]  fill_y0;
    logic [7:0]  fill_w;
    logic [6:0]  fill_h;
    logic [14:0] fill_color;
    logic        fill_busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [14:0] vga_color;
    logic        vga_plot;
    logic        idle;

    int checks = 0;
    int errors = 0;

    logic [29:0] plotq[$];
    logic [29:0] expq[$];

    always #5 clock = ~clock;

    vga_plot_scheduler #(.FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .fill_start(fill_start),
        .fill_x0   (fill_x0),
        .fill_y0   (fill_y0),
        .fill_w    (fill_w),
        .fill_h    (fill_h),
        .fill_color(fill_color),
        .fill_busy (fill_busy),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_plot  (vga_plot),
        .idle      (idle)
    );

    // Record every plot cycle, sampled mid-cycle.
    always @(negedge clock) begin
        if (resetn && vga_plot)
            plotq.push_back({vga_x, vga_y, vga_color});
    end

    function automatic logic [29:0] pk(input int x, input int y, input int c);
        return {8'(x), 7'(y), 15'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (!idle && n < max) begin
            step();
            n++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    task automatic check_q(input string tag);
        check($sformatf("%s_count", tag), 32'(plotq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < plotq.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(plotq[i]), 32'(expq[i]));
    endtask

    task automatic set_fill(input int x0, input int y0, input int w, input int h, input int c);
        fill_x0    = 8'(x0);
        fill_y0    = 7'(y0);
        fill_w     = 8'(w);
        fill_h     = 7'(h);
        fill_color = 15'(c);
        fill_start = 1'b1;
    endtask

    int acc[8];
    int acc_exp[8] = '{0, 1, 2, 3, 4, 5, 6, 8};
    int idx, cyc, nf;
    logic rdy;

    initial begin
        resetn = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
        fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
        repeat (3) step();

        check("rst_plot",  32'(vga_plot),  32'd0);
        check("rst_ready", 32'(pix_ready), 32'd1);
        check("rst_idle",  32'(idle),      32'd1);
        check("rst_busy",  32'(fill_busy), 32'd0);
        check("rst_xy",    32'({vga_x, vga_y, vga_color}), 32'd0);
        resetn = 1'b1;
        step();

        // Single pixel into an idle block: plot two cycles after pix_valid.
        plotq.delete();
        pix_valid = 1'b1; pix_x = 8'd5; pix_y = 7'd7; pix_color = 15'h7FFF;
        step();
        pix_valid = 1'b0;
        check("p1_plot_early", 32'(vga_plot), 32'd0);
        check("p1_idle_busy",  32'(idle),     32'd0);
        step();
        check("p1_plot", 32'(vga_plot),  32'd1);
        check("p1_x",    32'(vga_x),     32'd5);
        check("p1_y",    32'(vga_y),     32'd7);
        check("p1_c",    32'(vga_color), 32'h7FFF);
        step();
        check("p1_plot_once", 32'(vga_plot), 32'd0);
        check("p1_hold_x",    32'(vga_x),    32'd5);
        check("p1_idle",      32'(idle),     32'd1);

        // Fill clipped at the bottom-right corner.
        plotq.delete();
        set_fill(158, 118, 4, 4, 15'h001F);
        step();
        fill_start = 1'b0;
        check("clip_busy", 32'(fill_busy), 32'd1);
        wait_idle(50, "clip_done");
        check("clip_busy_end", 32'(fill_busy), 32'd0);
        expq = '{pk(158, 118, 15'h001F), pk(159, 118, 15'h001F),
                 pk(158, 119, 15'h001F), pk(159, 119, 15'h001F)};
        check_q("clip");

        // Zero-width fill is ignored.
        plotq.delete();
        set_fill(10, 10, 0, 5, 15'h0123);
        step();
        fill_start = 1'b0;
        check("w0_busy", 32'(fill_busy), 32'd0);
        repeat (3) step();
        check("w0_plots", 32'(plotq.size()), 32'd0);

        // A second fill_start while running is ignored.
        plotq.delete();
        set_fill(10, 20, 3, 2, 15'h1234);
        step();
        set_fill(50, 50, 2, 2, 15'h4321);
        step();
        fill_start = 1'b0;
        wait_idle(50, "rerun_done");
        expq = '{pk(10, 20, 15'h1234), pk(11, 20, 15'h1234), pk(12, 20, 15'h1234),
                 pk(10, 21, 15'h1234), pk(11, 21, 15'h1234), pk(12, 21, 15'h1234)};
        check_q("rerun");

        // Back-to-back pixels while a 10x10 fill runs; FIFO fills up and back-pressures.
        plotq.delete();
        set_fill(0, 0, 10, 10, 15'h0AAA);
        idx = 0; cyc = 0;
        pix_valid = 1'b1; pix_x = 8'd20; pix_y = 7'd30; pix_color = 15'h7000;
        while (idx < 8 && cyc < 40) begin
            rdy = pix_ready;
            if (rdy) acc[idx] = cyc;
            step();
            cyc++;
            fill_start = 1'b0;
            if (rdy) begin
                idx++;
                if (idx < 8) begin
                    pix_x = 8'(20 + idx); pix_y = 7'(30 + idx); pix_color = 15'(32'h7000 + idx);
                end else begin
                    pix_valid = 1'b0;
                end
            end
        end
        pix_valid = 1'b0;
        check("bp_accepted", 32'(idx), 32'd8);
        for (int i = 0; i < idx; i++)
            check($sformatf("bp_acc_cyc_%0d", i), 32'(acc[i]), 32'(acc_exp[i]));
        wait_idle(300, "bp_done");
        check("bp_total", 32'(plotq.size()), 32'd108);
        if (plotq.size() >= 4) begin
            check("bp_rr0", 32'(plotq[0]), 32'(pk(20, 30, 15'h7000)));
            check("bp_rr1", 32'(plotq[1]), 32'(pk(0, 0, 15'h0AAA)));
            check("bp_rr2", 32'(plotq[2]), 32'(pk(21, 31, 15'h7001)));
            check("bp_rr3", 32'(plotq[3]), 32'(pk(1, 0, 15'h0AAA)));
            check("bp_last", 32'(plotq[plotq.size() - 1]), 32'(pk(9, 9, 15'h0AAA)));
        end
        nf = 0;
        foreach (plotq[i]) begin
            if (plotq[i][14:12] == 3'b111) begin
                check($sformatf("bp_order_%0d", nf), 32'(plotq[i]), 32'(pk(20 + nf, 30 + nf, 32'h7000 + nf)));
                nf++;
            end
        end
        check("bp_fifo_plots", 32'(nf), 32'd8);

        // Off-screen FIFO pixels are discarded; the last on-screen corner is kept.
        plotq.delete();
        pix_valid = 1'b1;
        pix_x = 8'd160; pix_y = 7'd5;   pix_color = 15'h0055; step();
        pix_x = 8'd5;   pix_y = 7'd120; pix_color = 15'h0055; step();
        pix_x = 8'd159; pix_y = 7'd119; pix_color = 15'h0055; step();
        pix_valid = 1'b0;
        wait_idle(20, "disc_done");
        expq = '{pk(159, 119, 15'h0055)};
        check_q("disc");

        // Reset in the middle of a 10x10 fill.
        plotq.delete();
        set_fill(0, 0, 10, 10, 15'h0001);
        step();
        fill_start = 1'b0;
        repeat (5) step();
        check("rst_mid_plot_before", 32'(vga_plot), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_plot", 32'(vga_plot),  32'd0);
        check("rst_mid_busy", 32'(fill_busy), 32'd0);
        step();
        step();
        resetn = 1'b1;
        plotq.delete();
        repeat (20) step();
        check("rst_mid_idle",  32'(idle),          32'd1);
        check("rst_mid_ready", 32'(pix_ready),     32'd1);
        check("rst_mid_plots", 32'(plotq.size()),  32'd0);

        // Contention right after reset: FIFO, fill, FIFO, fill, fill.
        plotq.delete();
        pix_valid = 1'b1; pix_x = 8'd40; pix_y = 7'd40; pix_color = 15'h0111;
        set_fill(0, 0, 3, 1, 15'h0222);
        step();
        fill_start = 1'b0;
        pix_x = 8'd41; pix_y = 7'd40; pix_color = 15'h0333;
        step();
        pix_valid = 1'b0;
        wait_idle(30, "rr_done");
        expq = '{pk(40, 40, 15'h0111), pk(0, 0, 15'h0222), pk(41, 40, 15'h0333),
                 pk(1, 0, 15'h0222), pk(2, 0, 15'h0222)};
        check_q("rr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
